// File: rtl/xres_filt_seq_if.sv
// rtl/xres_filt_seq_if.sv - pad reset filter / reset sequencer signal bundle
// master drives the pad and request inputs, slave is the sequencer.
interface xres_filt_seq_if;
  logic       xres_h_n_in;
  logic       sw_rst_req;
  logic       glitch_clr;
  logic       xres_filt;
  logic       rst_core_n;
  logic       rst_periph_n;
  logic [1:0] seq_state;
  logic [7:0] glitch_cnt;

  modport master (
    output xres_h_n_in, sw_rst_req, glitch_clr,
    input  xres_filt, rst_core_n, rst_periph_n, seq_state, glitch_cnt
  );

  modport slave (
    input  xres_h_n_in, sw_rst_req, glitch_clr,
    output xres_filt, rst_core_n, rst_periph_n, seq_state, glitch_cnt
  );
endinterface

// File: rtl/xres_filt_seq.sv
// rtl/xres_filt_seq.sv - pad reset synchronizer/debouncer with core-then-peripheral release
// Optional glitch counter enabled by XRES_FILT_SEQ_GLITCH_CNT_EN.
module xres_filt_seq #(
  parameter int FILT_CYCLES    = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int SEQ_GAP        = 4
) (
  input  logic           clock,
  input  logic           resetb,
  xres_filt_seq_if.slave bus
);

  typedef enum logic [1:0] {
    HOLD     = 2'b00,
    REL_CORE = 2'b01,
    RUN      = 2'b10
  } state_t;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_filt;
  logic [7:0]  r_filt_cnt;
  logic [15:0] r_stretch_cnt;
  logic [7:0]  r_gap_cnt;
  state_t      r_state;
  logic        r_core_n;
  logic        r_periph_n;

  logic        w_mismatch;
  logic        w_filt_done;
  logic        w_stretch_done;
  logic        w_gap_done;

  assign w_mismatch     = (r_sync2 != r_filt);
  assign w_filt_done    = w_mismatch && (({1'b0, r_filt_cnt} + 9'd1) == 9'(FILT_CYCLES));
  assign w_stretch_done = (({1'b0, r_stretch_cnt} + 17'd1) == 17'(STRETCH_CYCLES));
  assign w_gap_done     = (({1'b0, r_gap_cnt} + 9'd1) == 9'(SEQ_GAP));

  // Plain two-flop synchronizer; the filter only ever looks at r_sync2.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_filt     <= 1'b0;
      r_filt_cnt <= 8'd0;
    end else begin
      r_sync1 <= bus.xres_h_n_in;
      r_sync2 <= r_sync1;
      if (w_filt_done) begin
        r_filt     <= r_sync2;
        r_filt_cnt <= 8'd0;
      end else if (w_mismatch) begin
        r_filt_cnt <= r_filt_cnt + 8'd1;
      end else begin
        r_filt_cnt <= 8'd0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state       <= HOLD;
      r_stretch_cnt <= 16'd0;
      r_gap_cnt     <= 8'd0;
      r_core_n      <= 1'b0;
      r_periph_n    <= 1'b0;
    end else if (!r_filt || bus.sw_rst_req) begin
      r_state       <= HOLD;
      r_stretch_cnt <= 16'd0;
      r_gap_cnt     <= 8'd0;
      r_core_n      <= 1'b0;
      r_periph_n    <= 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          if (w_stretch_done) begin
            r_state       <= REL_CORE;
            r_stretch_cnt <= 16'd0;
            r_core_n      <= 1'b1;
          end else begin
            r_stretch_cnt <= r_stretch_cnt + 16'd1;
          end
        end
        REL_CORE: begin
          if (w_gap_done) begin
            r_state    <= RUN;
            r_gap_cnt  <= 8'd0;
            r_periph_n <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        RUN: begin
          r_core_n   <= 1'b1;
          r_periph_n <= 1'b1;
        end
        default: begin
          r_state       <= HOLD;
          r_stretch_cnt <= 16'd0;
          r_gap_cnt     <= 8'd0;
          r_core_n      <= 1'b0;
          r_periph_n    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.xres_filt    = r_filt;
  assign bus.rst_core_n   = r_core_n;
  assign bus.rst_periph_n = r_periph_n;
  assign bus.seq_state    = r_state;

`ifdef XRES_FILT_SEQ_GLITCH_CNT_EN
  logic       w_glitch;
  logic [7:0] r_glitch_cnt;

  // A mismatch run that ends before the filter fires is a rejected pulse.
  assign w_glitch = !w_mismatch && (r_filt_cnt != 8'd0);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_glitch_cnt <= 8'd0;
    end else if (bus.glitch_clr) begin
      r_glitch_cnt <= 8'd0;
    end else if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
      r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end
  end

  assign bus.glitch_cnt = r_glitch_cnt;
`else
  assign bus.glitch_cnt = 8'd0;
`endif

endmodule
